// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// requester and a data requester. Data accesses win by default; a saturating
// starvation counter forces a fetch grant after STARVE_LIMIT consecutive data
// grants while a fetch is waiting. One access is in flight at a time.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // fetch port
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,
    // data port
    input  logic        dm_req_i,
    input  logic [3:0]  dm_w_en_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ready_o,
    // memory port
    output logic        mem_req_o,
    output logic [3:0]  mem_w_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    // pipeline freeze
    output logic        stall_o
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              mem_req_q;
    logic [3:0]        mem_w_en_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              if_ready_q, dm_ready_q;
    logic [31:0]       if_rdata_q, dm_rdata_q;

    logic if_elig, dm_elig, starved, turnaround;
    logic grant_if, grant_dm;

    // A requester is eligible only while its own ready is not pulsing, so a
    // request still held high during completion cannot be granted twice.
    assign if_elig = if_req_i & ~if_ready_q;
    assign dm_elig = dm_req_i & ~dm_ready_q;
    assign starved = (starve_q == CNT_MAX);
    // Nothing is granted in a ready-pulse cycle: that cycle lets the finishing
    // requester present its next access so it competes fairly on the next edge.
    assign turnaround = if_ready_q | dm_ready_q;

    // Arbitration and starvation-counter next state.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        starve_d = starve_q;
        if (state_q == IDLE && !turnaround) begin
            if (if_elig && (!dm_elig || starved)) begin
                grant_if = 1'b1;
            end else if (dm_elig) begin
                grant_dm = 1'b1;
            end
        end
        if (!if_req_i || grant_if) begin
            starve_d = '0;
        end else if (grant_dm && !starved) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Access FSM with registered memory-side and requester-side outputs.
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_w_en_q  <= 4'b0000;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= 32'h0;
            dm_rdata_q  <= 32'h0;
        end else begin
            starve_q   <= starve_d;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // mem_ack seen here is stale (e.g. from an access cut off by
                    // reset) and is deliberately ignored.
                    if (grant_if) begin
                        state_q     <= BUSY_IF;
                        mem_req_q   <= 1'b1;
                        mem_w_en_q  <= 4'b0000;
                        mem_addr_q  <= if_addr_i;
                        mem_wdata_q <= 32'h0;
                    end else if (grant_dm) begin
                        state_q     <= BUSY_DM;
                        mem_req_q   <= 1'b1;
                        mem_w_en_q  <= dm_w_en_i;
                        mem_addr_q  <= dm_addr_i;
                        mem_wdata_q <= dm_wdata_i;
                    end
                end
                BUSY_IF: begin
                    if (mem_ack_i) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        if_rdata_q <= mem_rdata_i;
                        if_ready_q <= 1'b1;
                    end
                end
                BUSY_DM: begin
                    // Stores capture read data too; the requester ignores it.
                    if (mem_ack_i) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        dm_rdata_q <= mem_rdata_i;
                        dm_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_w_en_o  = mem_w_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_ready_o  = if_ready_q;
    assign dm_ready_o  = dm_ready_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;

    // The pipeline freezes while any request is outstanding and not completing.
    assign stall_o = (if_req_i & ~if_ready_q) | (dm_req_i & ~dm_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of per-cycle vectors for single and
// simultaneous accesses, then hand-written sequences for starvation, slow
// memory, back-to-back requests and reset during an access.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        dm_req_i;
    logic [3:0]  dm_w_en_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ready_o;
    logic        mem_req_o;
    logic [3:0]  mem_w_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_rdata_o (if_rdata_o),
        .if_ready_o (if_ready_o),
        .dm_req_i   (dm_req_i),
        .dm_w_en_i  (dm_w_en_i),
        .dm_addr_i  (dm_addr_i),
        .dm_wdata_i (dm_wdata_i),
        .dm_rdata_o (dm_rdata_o),
        .dm_ready_o (dm_ready_o),
        .mem_req_o  (mem_req_o),
        .mem_w_en_o (mem_w_en_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .stall_o    (stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic [3:0]  dm_w_en;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        logic        e_mem_req;
        logic [31:0] e_mem_addr;
        logic [3:0]  e_mem_w_en;
        logic [31:0] e_mem_wdata;
        logic        e_if_ready;
        logic [31:0] e_if_rdata;
        logic        e_dm_ready;
        logic [31:0] e_dm_rdata;
        logic        e_stall;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i    = 1'b0;
        if_addr_i   = 32'h0;
        dm_req_i    = 1'b0;
        dm_w_en_i   = 4'b0000;
        dm_addr_i   = 32'h0;
        dm_wdata_i  = 32'h0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, " mem_req"},   32'(mem_req_o),   32'h0);
        check({tag, " mem_w_en"},  32'(mem_w_en_o),  32'h0);
        check({tag, " mem_addr"},  mem_addr_o,       32'h0);
        check({tag, " mem_wdata"}, mem_wdata_o,      32'h0);
        check({tag, " if_ready"},  32'(if_ready_o),  32'h0);
        check({tag, " dm_ready"},  32'(dm_ready_o),  32'h0);
        check({tag, " if_rdata"},  if_rdata_o,       32'h0);
        check({tag, " dm_rdata"},  dm_rdata_o,       32'h0);
    endtask

    initial begin
        logic [31:0] g_addr[8];
        logic [3:0]  g_wen[8];
        int          g_cyc[8];
        int          ngrant;
        int          pulses;
        logic        prev_req;

        // if_req if_addr dm_req w_en dm_addr dm_wdata ack rdata |
        // mem_req mem_addr mem_w_en mem_wdata if_ready if_rdata dm_ready dm_rdata stall
        vecs[0] = '{1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b1, 32'h100, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1};
        vecs[1] = '{1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h13,
                    1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 32'h13, 1'b0, 32'h0, 1'b0};
        vecs[2] = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b0, 32'h100, 4'h0, 32'h0, 1'b0, 32'h13, 1'b0, 32'h0, 1'b0};
        vecs[3] = '{1'b1, 32'h200, 1'b1, 4'hF, 32'h1000, 32'hDEADBEEF, 1'b0, 32'h0,
                    1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 1'b0, 32'h13, 1'b0, 32'h0, 1'b1};
        vecs[4] = '{1'b1, 32'h200, 1'b1, 4'hF, 32'h1000, 32'hDEADBEEF, 1'b1, 32'h55AA55AA,
                    1'b0, 32'h1000, 4'hF, 32'hDEADBEEF, 1'b0, 32'h13, 1'b1, 32'h55AA55AA, 1'b1};
        vecs[5] = '{1'b1, 32'h200, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b0, 32'h1000, 4'hF, 32'hDEADBEEF, 1'b0, 32'h13, 1'b0, 32'h55AA55AA, 1'b1};
        vecs[6] = '{1'b1, 32'h200, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b1, 32'h200, 4'h0, 32'h0, 1'b0, 32'h13, 1'b0, 32'h55AA55AA, 1'b1};
        vecs[7] = '{1'b1, 32'h200, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hCAFEF00D,
                    1'b0, 32'h200, 4'h0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 32'h55AA55AA, 1'b0};
        vecs[8] = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF,
                    1'b0, 32'h200, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 32'h55AA55AA, 1'b0};
        vecs[9] = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0,
                    1'b0, 32'h200, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 32'h55AA55AA, 1'b0};

        // ---------------- reset state ----------------
        rst_ni = 1'b0;
        idle_inputs();
        #12;
        check_all_reset("reset");
        check("reset stall", 32'(stall_o), 32'h0);

        // ---------------- vector table (first grant on first edge after release) ----
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            if_req_i    = vecs[i].if_req;
            if_addr_i   = vecs[i].if_addr;
            dm_req_i    = vecs[i].dm_req;
            dm_w_en_i   = vecs[i].dm_w_en;
            dm_addr_i   = vecs[i].dm_addr;
            dm_wdata_i  = vecs[i].dm_wdata;
            mem_ack_i   = vecs[i].mem_ack;
            mem_rdata_i = vecs[i].mem_rdata;
            step();
            check($sformatf("row%0d mem_req", i),   32'(mem_req_o),  32'(vecs[i].e_mem_req));
            check($sformatf("row%0d mem_addr", i),  mem_addr_o,      vecs[i].e_mem_addr);
            check($sformatf("row%0d mem_w_en", i),  32'(mem_w_en_o), 32'(vecs[i].e_mem_w_en));
            check($sformatf("row%0d mem_wdata", i), mem_wdata_o,     vecs[i].e_mem_wdata);
            check($sformatf("row%0d if_ready", i),  32'(if_ready_o), 32'(vecs[i].e_if_ready));
            check($sformatf("row%0d if_rdata", i),  if_rdata_o,      vecs[i].e_if_rdata);
            check($sformatf("row%0d dm_ready", i),  32'(dm_ready_o), 32'(vecs[i].e_dm_ready));
            check($sformatf("row%0d dm_rdata", i),  dm_rdata_o,      vecs[i].e_dm_rdata);
            check($sformatf("row%0d stall", i),     32'(stall_o),    32'(vecs[i].e_stall));
        end

        // ---------------- starvation: both requesters held, immediate ack ----------
        idle_inputs();
        if_req_i   = 1'b1;
        if_addr_i  = 32'h300;
        dm_req_i   = 1'b1;
        dm_w_en_i  = 4'b0011;
        dm_addr_i  = 32'h2000;
        dm_wdata_i = 32'h0BAD0000;
        ngrant     = 0;
        for (int cyc = 0; cyc < 60 && ngrant < 6; cyc++) begin
            mem_ack_i   = mem_req_o;
            mem_rdata_i = 32'h77000000 + 32'(cyc);
            prev_req    = mem_req_o;
            step();
            if (mem_req_o && !prev_req) begin
                g_addr[ngrant] = mem_addr_o;
                g_wen[ngrant]  = mem_w_en_o;
                g_cyc[ngrant]  = cyc;
                ngrant++;
            end
            if (dm_ready_o) dm_addr_i = dm_addr_i + 32'h4;
            if (if_ready_o) if_addr_i = if_addr_i + 32'h4;
        end
        check("starve grant count", 32'(ngrant), 32'd6);
        if (ngrant == 6) begin
            check("starve g0 addr", g_addr[0], 32'h2000);
            check("starve g1 addr", g_addr[1], 32'h2004);
            check("starve g2 addr", g_addr[2], 32'h2008);
            check("starve g3 addr", g_addr[3], 32'h200C);
            check("starve g3 w_en", 32'(g_wen[3]), 32'h3);
            check("starve g4 addr (fetch)", g_addr[4], 32'h300);
            check("starve g4 w_en (fetch)", 32'(g_wen[4]), 32'h0);
            check("starve g5 addr (counter cleared)", g_addr[5], 32'h2010);
            check("starve g5 w_en", 32'(g_wen[5]), 32'h3);
            check("grant interval", 32'(g_cyc[1] - g_cyc[0]), 32'd3);
        end
        // drain the in-flight access
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            mem_ack_i = mem_req_o;
            step();
        end
        check("drain mem_req", 32'(mem_req_o), 32'h0);

        // ---------------- slow memory, requester drops req after grant -------------
        idle_inputs();
        dm_req_i  = 1'b1;
        dm_w_en_i = 4'b0000;
        dm_addr_i = 32'h4000;
        step();
        check("slow grant mem_req", 32'(mem_req_o), 32'h1);
        check("slow grant addr", mem_addr_o, 32'h4000);
        dm_req_i  = 1'b0;
        dm_addr_i = 32'hFFFF0000;
        pulses    = 0;
        for (int w = 0; w < 5; w++) begin
            step();
            check($sformatf("slow wait%0d mem_req", w), 32'(mem_req_o), 32'h1);
            check($sformatf("slow wait%0d addr", w), mem_addr_o, 32'h4000);
            check($sformatf("slow wait%0d w_en", w), 32'(mem_w_en_o), 32'h0);
            if (dm_ready_o) pulses++;
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h12345678;
        step();
        if (dm_ready_o) pulses++;
        check("slow done dm_rdata", dm_rdata_o, 32'h12345678);
        check("slow done mem_req", 32'(mem_req_o), 32'h0);
        mem_ack_i = 1'b0;
        for (int w = 0; w < 3; w++) begin
            step();
            if (dm_ready_o) pulses++;
        end
        check("slow ready pulses", 32'(pulses), 32'd1);

        // ---------------- back-to-back data accesses --------------------------------
        idle_inputs();
        dm_req_i  = 1'b1;
        dm_addr_i = 32'h6000;
        step();
        check("b2b first addr", mem_addr_o, 32'h6000);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h11111111;
        step();
        check("b2b first ready", 32'(dm_ready_o), 32'h1);
        check("b2b first rdata", dm_rdata_o, 32'h11111111);
        mem_ack_i = 1'b0;
        dm_addr_i = 32'h6004;
        step();
        check("b2b no regrant in ready cycle", 32'(mem_req_o), 32'h0);
        check("b2b ready single", 32'(dm_ready_o), 32'h0);
        step();
        check("b2b second mem_req", 32'(mem_req_o), 32'h1);
        check("b2b second addr", mem_addr_o, 32'h6004);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h22222222;
        step();
        check("b2b second rdata", dm_rdata_o, 32'h22222222);
        idle_inputs();
        step();

        // ---------------- reset in the middle of a store ----------------------------
        dm_req_i   = 1'b1;
        dm_w_en_i  = 4'hF;
        dm_addr_i  = 32'h5000;
        dm_wdata_i = 32'hA5A5A5A5;
        step();
        check("rst-mid busy mem_req", 32'(mem_req_o), 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst-mid async mem_req", 32'(mem_req_o), 32'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        dm_req_i    = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h99999999;
        step();
        check_all_reset("rst-mid late ack");
        mem_ack_i = 1'b0;
        step();
        check("rst-mid no dm_ready", 32'(dm_ready_o), 32'h0);
        check("rst-mid idle mem_req", 32'(mem_req_o), 32'h0);
        check("rst-mid stall", 32'(stall_o), 32'h0);
        if_req_i  = 1'b1;
        if_addr_i = 32'h700;
        step();
        check("rst-mid regrant mem_req", 32'(mem_req_o), 32'h1);
        check("rst-mid regrant addr", mem_addr_o, 32'h700);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch is pending.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-004 if_req  in  1  fetch request; held high, if_addr stable, until if_ready.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_rdata  out  32  registered fetch data, valid while if_ready=1.
REQ-007 if_ready  out  1  one-cycle pulse, fetch complete.
REQ-008 dm_req  in  1  data request; held high, inputs stable, until dm_ready.
REQ-009 dm_w_en  in  4  byte write enables; 4'b0000 = load.
REQ-010 dm_addr  in  32  data byte address.
REQ-011 dm_wdata  in  32  store data.
REQ-012 dm_rdata  out  32  registered load data, valid while dm_ready=1.
REQ-013 dm_ready  out  1  one-cycle pulse, data access complete.
REQ-014 mem_req  out  1  request to single-port memory, held until mem_ack.
REQ-015 mem_w_en, mem_addr, mem_wdata  out  4/32/32  registered copies of granted request.
REQ-016 mem_ack  in  1  memory completion; mem_rdata valid same cycle.
REQ-017 mem_rdata  in  32  memory read data.
REQ-018 stall  out  1  pipeline freeze.

Function
REQ-019 States: IDLE, BUSY_IF, BUSY_DM.
REQ-020 IDLE: no eligible request -> stay IDLE.
REQ-021 IDLE, eligible request: grant -> latch addr/w_en/wdata onto mem_* (mem_w_en=0000 for fetch, mem_wdata=0), mem_req=1 next cycle, enter BUSY_IF or BUSY_DM.
REQ-022 Eligible = req high and that requester's ready not high this cycle; no regrant in a ready-pulse cycle.
REQ-023 Priority: data over fetch, except starvation override of REQ-025.
REQ-024 Starvation counter, width ceil(log2(STARVE_LIMIT+1)): +1 per DM grant while if_req=1; cleared on IF grant or whenever if_req=0; saturates at STARVE_LIMIT.
REQ-025 Counter == STARVE_LIMIT and fetch eligible in IDLE -> grant fetch even if dm_req=1.
REQ-026 BUSY_x, mem_ack=0 -> hold state, mem_req=1, mem_* unchanged.
REQ-027 BUSY_x, mem_ack=1 -> capture mem_rdata into x_rdata (dm_rdata captured for stores too), pulse x_ready next cycle, mem_req=0 next cycle, enter IDLE.
REQ-028 Min latency req->ready: 2 cycles + memory latency; one access per 3 cycles when mem_ack is immediate.
REQ-029 Requester dropping req after grant: transaction still completes and ready still pulses.
REQ-030 Requester dropping req before grant: no access.
REQ-031 mem_ack in IDLE: ignored, no state or output change.
REQ-032 stall = (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational.
REQ-033 if_rdata/dm_rdata hold last captured value until next capture.

Reset
REQ-034 rst=0 asynchronously: state IDLE; mem_req=0; mem_w_en=0; mem_addr=0; mem_wdata=0; if_ready=dm_ready=0; if_rdata=dm_rdata=0; counter=0.
REQ-035 Reset during BUSY_x: access abandoned; no ready pulse; later mem_ack ignored per REQ-031.
REQ-036 First grant possible on first rising edge with rst=1.

Verification
REQ-037 Single fetch: if_req=1, if_addr=0x100, mem_ack one cycle after mem_req, mem_rdata=0x00000013 -> mem_addr=0x100, mem_w_en=0000, if_ready pulse once with if_rdata=0x00000013, stall=1 until that cycle.
REQ-038 Simultaneous requests: if_req=1 (0x200), dm_req=1 sw (0x1000, wdata=0xDEADBEEF, w_en=1111) -> data served first, mem_w_en=1111; fetch served next; dm_ready before if_ready.
REQ-039 Starvation: if_req=1 held, dm_req=1 held with new address after each dm_ready, STARVE_LIMIT=4 -> exactly 4 DM grants, then IF grant, counter cleared.
REQ-040 Slow memory: mem_ack delayed 5 cycles -> mem_req high, mem_* stable for all 5 wait cycles; single ready pulse.
REQ-041 Reset mid-access: rst=0 in BUSY_DM, then mem_ack=1 after release -> no dm_ready, state IDLE, all outputs at REQ-034 values.
REQ-042 Back-to-back: dm_req held high through dm_ready, new address next cycle -> no duplicate grant in ready cycle; second access uses new address.
